mmm_sched_ctrl: RTL and testbench

//  Sequencing controller for the matrix-multiply datapath (input_mems -> mac_pipe -> fifo_out).

---
 rtl/mmm_sched_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mmm_sched_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mmm_sched_ctrl.sv
// Matrix-multiply sequencer: walks C[r][c] over k, issues A/B addresses and
// delay-aligned valid/clear/write strobes under FIFO credit flow control.
module mmm_sched_ctrl #(
  parameter int unsigned M       = 7,
  parameter int unsigned N       = 9,
  parameter int unsigned MAXK    = 8,
  parameter int unsigned VLD_DLY = 1,
  parameter int unsigned WR_DLY  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        matrices_loaded,
  input  logic [$clog2(MAXK+1)-1:0]   K,
  input  logic [$clog2(N+1)-1:0]      fifo_capacity,
  output logic                        compute_finished,
  output logic [$clog2(M*MAXK)-1:0]   A_read_addr,
  output logic [$clog2(MAXK*N)-1:0]   B_read_addr,
  output logic                        valid_input,
  output logic                        clear_acc,
  output logic                        fifo_wr_en
);

  localparam int unsigned KW  = $clog2(MAXK + 1);
  localparam int unsigned PW  = $clog2(N + 1);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AW  = $clog2(M * MAXK);
  localparam int unsigned BW  = $clog2(MAXK * N);
  localparam int unsigned RW  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned KCW = (MAXK > 1) ? $clog2(MAXK) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(M - 1);
  localparam logic [NW-1:0] C_LAST = NW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_CREDIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_lat_q, k_lat_d;
  logic [RW-1:0]        r_q, r_d;
  logic [NW-1:0]        c_q, c_d;
  logic [KCW-1:0]       k_q, k_d;
  logic [AW-1:0]        a_row_base_q, a_row_base_d;
  logic [BW-1:0]        b_ptr_q, b_ptr_d;
  logic [PW-1:0]        pending_q, pending_d;
  logic [VLD_DLY-1:0]   vld_sr_q, vld_sr_d;
  logic [WR_DLY-1:0]    wr_sr_q, wr_sr_d;

  logic                 issue;
  logic                 last_k;
  logic signed [CW-1:0] credit;

  always_comb begin
    credit = $signed({1'b0, fifo_capacity}) - $signed({1'b0, pending_q});
  end

  always_comb begin
    state_d      = state_q;
    k_lat_d      = k_lat_q;
    r_d          = r_q;
    c_d          = c_q;
    k_d          = k_q;
    a_row_base_d = a_row_base_q;
    b_ptr_d      = b_ptr_q;
    issue        = 1'b0;
    last_k       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (matrices_loaded) begin
          k_lat_d      = K;
          r_d          = '0;
          c_d          = '0;
          k_d          = '0;
          a_row_base_d = '0;
          b_ptr_d      = '0;
          state_d      = (K == '0) ? S_DONE : S_RUN;
        end
      end
      // WAIT_CREDIT shares the issue path: k is always 0 there, so the same
      // credit test releases it and issues k=0 in the same cycle.
      S_RUN, S_WAIT_CREDIT: begin
        if ((k_q != '0) || (credit > 0)) begin
          issue   = 1'b1;
          state_d = S_RUN;
          if (KW'(k_q) == (k_lat_q - KW'(1))) begin
            last_k = 1'b1;
            k_d    = '0;
            if (c_q == C_LAST) begin
              c_d          = '0;
              r_d          = r_q + RW'(1);
              a_row_base_d = a_row_base_q + AW'(k_lat_q);
              b_ptr_d      = '0;
              if (r_q == R_LAST) begin
                state_d = S_DRAIN;
              end
            end else begin
              c_d     = c_q + NW'(1);
              b_ptr_d = BW'(c_q) + BW'(1);
            end
          end else begin
            k_d     = k_q + KCW'(1);
            b_ptr_d = b_ptr_q + BW'(N);
          end
        end else begin
          state_d = S_WAIT_CREDIT;
        end
      end
      S_DRAIN: begin
        if (pending_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!matrices_loaded) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_sr_d  = VLD_DLY'({vld_sr_q, issue});
    wr_sr_d   = WR_DLY'({wr_sr_q, issue & last_k});
    pending_d = pending_q;
    case ({issue & last_k, fifo_wr_en})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      k_lat_q      <= '0;
      r_q          <= '0;
      c_q          <= '0;
      k_q          <= '0;
      a_row_base_q <= '0;
      b_ptr_q      <= '0;
      pending_q    <= '0;
      vld_sr_q     <= '0;
      wr_sr_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_lat_q      <= k_lat_d;
      r_q          <= r_d;
      c_q          <= c_d;
      k_q          <= k_d;
      a_row_base_q <= a_row_base_d;
      b_ptr_q      <= b_ptr_d;
      pending_q    <= pending_d;
      vld_sr_q     <= vld_sr_d;
      wr_sr_q      <= wr_sr_d;
    end
  end

  always_comb begin
    compute_finished = (state_q == S_DONE);
    A_read_addr      = issue ? (a_row_base_q + AW'(k_q)) : '0;
    B_read_addr      = issue ? b_ptr_q : '0;
    valid_input      = vld_sr_q[VLD_DLY-1];
    fifo_wr_en       = wr_sr_q[WR_DLY-1];
    clear_acc        = wr_sr_q[WR_DLY-1];
  end

endmodule

// File: tb/tb_mmm_sched_ctrl.sv
// Randomized self-checking bench for mmm_sched_ctrl against an
// element-index reference model of the schedule.
module tb_mmm_sched_ctrl;

  localparam int unsigned M       = 2;
  localparam int unsigned N       = 3;
  localparam int unsigned MAXK    = 8;
  localparam int unsigned VLD_DLY = 1;
  localparam int unsigned WR_DLY  = 3;
  localparam int unsigned KW      = $clog2(MAXK + 1);
  localparam int unsigned CAPW    = $clog2(N + 1);
  localparam int unsigned AW      = $clog2(M * MAXK);
  localparam int unsigned BW      = $clog2(MAXK * N);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            matrices_loaded = 1'b0;
  logic [KW-1:0]   K = '0;
  logic [CAPW-1:0] fifo_capacity = '0;
  logic            compute_finished;
  logic [AW-1:0]   A_read_addr;
  logic [BW-1:0]   B_read_addr;
  logic            valid_input;
  logic            clear_acc;
  logic            fifo_wr_en;

  mmm_sched_ctrl #(
    .M(M), .N(N), .MAXK(MAXK), .VLD_DLY(VLD_DLY), .WR_DLY(WR_DLY)
  ) dut (
    .clk(clk), .reset(reset), .matrices_loaded(matrices_loaded), .K(K),
    .fifo_capacity(fifo_capacity), .compute_finished(compute_finished),
    .A_read_addr(A_read_addr), .B_read_addr(B_read_addr),
    .valid_input(valid_input), .clear_acc(clear_acc), .fifo_wr_en(fifo_wr_en)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned vld_cnt  = 0;
  int unsigned wr_cnt   = 0;
  int unsigned cap_mode = 0;
  int unsigned cap_val  = N;
  bit          chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Capacity driver: constant or random each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (cap_mode == 1) fifo_capacity = CAPW'($urandom_range(0, N));
      else               fifo_capacity = CAPW'(cap_val);
    end
  end

  // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done.
  // Element index n maps to (r,c,k) by division; the products in flight are
  // counted from issue time to the write WR_DLY cycles later.
  int unsigned phase = 0;
  int unsigned kl = 0;
  int unsigned n_idx = 0;
  int unsigned pend = 0;
  bit [7:0]    ih = '0;
  bit [7:0]    lh = '0;

  initial begin
    forever begin
      @(negedge clk);
      begin
        int unsigned nphase, ea, eb, kk;
        int          cred;
        bit          ei, el, wexp;
        nphase = phase; ei = 1'b0; el = 1'b0; ea = 0; eb = 0;
        case (phase)
          0: if (matrices_loaded) begin
               kl = K; n_idx = 0;
               nphase = (K == 0) ? 3 : 1;
             end
          1: begin
               kk   = n_idx % kl;
               cred = int'(fifo_capacity) - int'(pend);
               if (kk != 0 || cred > 0) begin
                 ei = 1'b1;
                 el = (kk == kl - 1);
                 ea = (n_idx / (N * kl)) * kl + kk;
                 eb = kk * N + (n_idx / kl) % N;
                 n_idx++;
                 if (n_idx == M * N * kl) nphase = 2;
               end
             end
          2: if (pend == 0) nphase = 3;
          default: if (!matrices_loaded) nphase = 0;
        endcase
        wexp = lh[WR_DLY-1];
        if (chk_en) begin
          check_eq("a_addr",   32'(A_read_addr), ei ? ea : 0);
          check_eq("b_addr",   32'(B_read_addr), ei ? eb : 0);
          check_eq("valid",    32'(valid_input), 32'(ih[VLD_DLY-1]));
          check_eq("wr_en",    32'(fifo_wr_en), 32'(wexp));
          check_eq("clear",    32'(clear_acc), 32'(wexp));
          check_eq("finished", 32'(compute_finished), (phase == 3) ? 1 : 0);
          if (fifo_wr_en) check_eq("pend_le_n", (pend <= N) ? 1 : 0, 1);
        end
        if (valid_input === 1'b1) vld_cnt++;
        if (fifo_wr_en === 1'b1)  wr_cnt++;
        pend  = pend + (el ? 1 : 0) - (wexp ? 1 : 0);
        ih    = {ih[6:0], ei};
        lh    = {lh[6:0], el};
        phase = nphase;
        if (reset) begin
          phase = 0; pend = 0; ih = '0; lh = '0; chk_en = 1'b1;
        end
      end
    end
  end

  task automatic wait_done();
    int unsigned t = 0;
    while (compute_finished !== 1'b1 && t < 3000) begin
      cyc(1);
      t++;
    end
    check_eq("done_timeout", 32'(compute_finished), 1);
  endtask

  task automatic run_job(input int unsigned kval, input int unsigned mode, input int unsigned cval);
    K = KW'(kval); cap_mode = mode; cap_val = cval;
    vld_cnt = 0; wr_cnt = 0;
    matrices_loaded = 1'b1;
    wait_done();
    check_eq("wr_count",  wr_cnt,  (kval != 0) ? M * N : 0);
    check_eq("vld_count", vld_cnt, M * N * kval);
    cyc(4);
    matrices_loaded = 1'b0;
    cyc(3);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Basic 2x3, K=2, full capacity
    run_job(2, 0, N);

    // Zero credit holds the run; a single credit pulse lets one product through
    K = KW'(2); cap_mode = 0; cap_val = 0; vld_cnt = 0; wr_cnt = 0;
    matrices_loaded = 1'b1;
    cyc(20);
    check_eq("stall_vld", vld_cnt, 0);
    cap_val = 1;
    cyc(1);
    cap_val = 0;
    cyc(20);
    check_eq("one_prod_vld", vld_cnt, 2);
    check_eq("one_prod_wr",  wr_cnt, 1);
    cap_val = N;
    wait_done();
    check_eq("resume_wr", wr_cnt, M * N);
    cyc(2);
    matrices_loaded = 1'b0;
    cyc(3);

    // Single credit throughout, then full-depth rerun, then K edge cases
    run_job(3, 0, 1);
    run_job(MAXK, 1, 0);
    run_job(0, 0, N);
    run_job(1, 0, N);
    run_job(1, 1, 0);

    // Reset in the middle of a run with strobes in flight
    K = KW'(3); cap_mode = 0; cap_val = N;
    matrices_loaded = 1'b1;
    cyc(8);
    reset = 1'b1;
    matrices_loaded = 1'b0;
    cyc(1);
    check_eq("rst_valid", 32'(valid_input), 0);
    check_eq("rst_wr",    32'(fifo_wr_en), 0);
    check_eq("rst_clear", 32'(clear_acc), 0);
    check_eq("rst_a",     32'(A_read_addr), 0);
    check_eq("rst_b",     32'(B_read_addr), 0);
    check_eq("rst_fin",   32'(compute_finished), 0);
    reset = 1'b0;
    cyc(3);

    // Randomized jobs
    for (int i = 0; i < 6; i++) begin
      run_job($urandom_range(0, MAXK), $urandom_range(0, 1), $urandom_range(1, N));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
